// File: rtl/alu_result_collector.sv
// Result collector behind the ALU: a small FIFO of {opcode, result, flags} with
// valid/ready on both sides, plus sticky flag accumulation and an accepted-result counter.
module alu_result_collector #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [3:0]               in_opcode,
  input  logic [WIDTH-1:0]         in_result,
  input  logic                     in_carry,
  input  logic                     in_zero,
  input  logic                     in_sign,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [3:0]               out_opcode,
  output logic [WIDTH-1:0]         out_result,
  output logic                     out_carry,
  output logic                     out_zero,
  output logic                     out_sign,
  input  logic                     clr_sticky,
  output logic                     sticky_carry,
  output logic                     sticky_zero,
  output logic                     sticky_sign,
  output logic                     illegal_op,
  output logic [CNT_W-1:0]         op_count,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = 4 + WIDTH + 3;
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [EW-1:0] head;
  logic          push;
  logic          pop;
  logic          in_illegal;

  // in_ready depends only on registered occupancy, never on out_ready
  assign in_ready   = (level != FULL_LEVEL);
  assign out_valid  = (level != '0);
  assign push       = in_valid && in_ready;
  assign pop        = out_valid && out_ready;
  assign in_illegal = (in_opcode > 4'd4);

  assign head = mem[rd_ptr];
  assign {out_opcode, out_result, out_carry, out_zero, out_sign} = head;

  // Storage is cleared on reset so the head fields read as zero afterwards
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr] <= {in_opcode, in_result, in_carry, in_zero, in_sign};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        level <= level + 1'b1;
      end else if (pop && !push) begin
        level <= level - 1'b1;
      end
    end
  end

  // A clear coinciding with a push restarts accumulation from that entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_carry <= 1'b0;
      sticky_zero  <= 1'b0;
      sticky_sign  <= 1'b0;
      illegal_op   <= 1'b0;
      op_count     <= '0;
    end else if (clr_sticky) begin
      if (push) begin
        sticky_carry <= in_carry;
        sticky_zero  <= in_zero;
        sticky_sign  <= in_sign;
        illegal_op   <= in_illegal;
        op_count     <= CNT_W'(1);
      end else begin
        sticky_carry <= 1'b0;
        sticky_zero  <= 1'b0;
        sticky_sign  <= 1'b0;
        illegal_op   <= 1'b0;
        op_count     <= '0;
      end
    end else if (push) begin
      sticky_carry <= sticky_carry | in_carry;
      sticky_zero  <= sticky_zero | in_zero;
      sticky_sign  <= sticky_sign | in_sign;
      illegal_op   <= illegal_op | in_illegal;
      op_count     <= op_count + 1'b1;
    end
  end

endmodule
